// File: rtl/btn_pkg.sv
// Shared constants and width helper for the button debounce bank.
package btn_pkg;

  localparam logic ACT_LOW  = 1'b0;
  localparam logic ACT_HIGH = 1'b1;

  // Defaults for a 24 MHz clock: 10 ms debounce, 1 s long press, 200 ms repeat.
  localparam int unsigned CN_24M  = 240000;
  localparam int unsigned LCN_24M = 24000000;
  localparam int unsigned RCN_24M = 4800000;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce_chn.sv
// One debounce channel: synchroniser, debounce counter, hold counter, events.
// Optional auto-repeat of the long-press event under BTN_DEBOUNCE_AUTOREPEAT_EN.
module btn_debounce_chn
  import btn_pkg::*;
#(
  parameter int unsigned CN  = CN_24M,
  parameter int unsigned LCN = LCN_24M,
  parameter int unsigned RCN = RCN_24M
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_n,
  output logic o_d,
  output logic o_rise,
  output logic o_fall,
  output logic o_long,
  output logic o_held
);

  localparam int unsigned CW = cnt_w(CN);
  localparam int unsigned HW = cnt_w(LCN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CN - 1);
  localparam logic [HW-1:0] HC_MAX   = HW'(LCN);
  localparam logic [HW-1:0] HC_PRE   = HW'(LCN - 1);

  logic          r_sync1, r_sync2, r_d;
  logic          r_rise, r_fall, r_long, r_held;
  logic [CW-1:0] r_cnt;
  logic [HW-1:0] r_hc;
  logic          w_flip, w_d_next, w_long_first, w_long_rpt;

  assign w_flip       = (r_sync2 != r_d) && (r_cnt == CNT_LAST);
  assign w_d_next     = r_d ^ w_flip;
  assign w_long_first = r_d && (r_hc == HC_PRE);

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
  localparam int unsigned RW = cnt_w(RCN);
  localparam logic [RW-1:0] RC_LAST = RW'(RCN - 1);

  logic [RW-1:0] r_rc;

  assign w_long_rpt = r_d && r_held && (r_rc == RC_LAST);

  // Repeat phase starts the cycle after the first long-press pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rc <= '0;
    end else if (!r_d || !r_held || w_long_rpt) begin
      r_rc <= '0;
    end else begin
      r_rc <= r_rc + 1'b1;
    end
  end
`else
  logic w_unused_rcn;
  assign w_unused_rcn = (RCN == 0);
  assign w_long_rpt   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_d     <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_hc    <= '0;
      r_long  <= 1'b0;
      r_held  <= 1'b0;
    end else begin
      r_sync1 <= i_n;
      r_sync2 <= r_sync1;
      // Any cycle of agreement restarts the count, rejecting glitches.
      if ((r_sync2 == r_d) || w_flip) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_d    <= w_d_next;
      r_rise <= w_flip & ~r_d;
      r_fall <= w_flip & r_d;
      if (!r_d) begin
        r_hc <= '0;
      end else if (r_hc != HC_MAX) begin
        r_hc <= r_hc + 1'b1;
      end
      r_long <= w_long_first | w_long_rpt;
      r_held <= w_d_next & (r_held | w_long_first);
    end
  end

  assign o_d    = r_d;
  assign o_rise = r_rise;
  assign o_fall = r_fall;
  assign o_long = r_long;
  assign o_held = r_held;

endmodule

// File: rtl/btn_debounce_bank.sv
// Bank of CHN independent button debouncers with selectable pin polarity.
// Long-press auto-repeat is enabled by defining BTN_DEBOUNCE_AUTOREPEAT_EN.
module btn_debounce_bank
  import btn_pkg::*;
#(
  parameter int unsigned CHN = 4,
  parameter int unsigned CN  = CN_24M,
  parameter int unsigned LCN = LCN_24M,
  parameter int unsigned RCN = RCN_24M,
  parameter logic        POL = ACT_LOW
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [CHN-1:0] d_i,
  output logic [CHN-1:0] d_o,
  output logic [CHN-1:0] rise_o,
  output logic [CHN-1:0] fall_o,
  output logic [CHN-1:0] long_o,
  output logic [CHN-1:0] held_o
);

  logic [CHN-1:0] w_n;

  // Normalise so that a pressed button is always 1 inside the bank.
  assign w_n = d_i ^ {CHN{~POL}};

  generate
    for (genvar gi = 0; gi < CHN; gi++) begin : g_chn
      btn_debounce_chn #(
        .CN  (CN),
        .LCN (LCN),
        .RCN (RCN)
      ) u_chn (
        .clk     (clk),
        .reset_n (reset_n),
        .i_n     (w_n[gi]),
        .o_d     (d_o[gi]),
        .o_rise  (rise_o[gi]),
        .o_fall  (fall_o[gi]),
        .o_long  (long_o[gi]),
        .o_held  (held_o[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_btn_debounce_bank.sv
// Scoreboard bench for btn_debounce_bank (CHN=4, CN=8, LCN=32, RCN=16, active-low).
// Expects the repeat pulses only when BTN_DEBOUNCE_AUTOREPEAT_EN is defined.
module tb_btn_debounce_bank;

  logic       clk;
  logic       reset_n;
  logic [3:0] d_i;
  logic [3:0] d_o, rise_o, fall_o, long_o, held_o;

  btn_debounce_bank #(
    .CHN (4),
    .CN  (8),
    .LCN (32),
    .RCN (16),
    .POL (1'b0)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (d_i),
    .d_o     (d_o),
    .rise_o  (rise_o),
    .fall_o  (fall_o),
    .long_o  (long_o),
    .held_o  (held_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // Expected vector layout: {held, long, fall, rise, d}.
  typedef struct {
    int          cyc;
    string       tag;
    logic [19:0] vec;
  } sb_t;

  sb_t sb[$];

  function automatic void push(input int c, input string tag, input logic [3:0] d,
                               input logic [3:0] r, input logic [3:0] f,
                               input logic [3:0] l, input logic [3:0] h);
    sb_t e;
    e.cyc = c;
    e.tag = tag;
    e.vec = {h, l, f, r, d};
    sb.push_back(e);
  endfunction

  logic mon_en = 1'b0;

  // Scheduled cycles compare the whole output vector; all others must be event-free.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        chk({sb[0].tag, "_missed"}, cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        sb_t e;
        e = sb.pop_front();
        chk(e.tag, {held_o, long_o, fall_o, rise_o, d_o}, e.vec);
      end else begin
        chk("quiet_events", {long_o, fall_o, rise_o}, 12'h000);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int e0, e1;

  initial begin
    d_i     = 4'hF;
    reset_n = 1'b0;
    step(3);
    chk("reset_outputs", {held_o, long_o, fall_o, rise_o, d_o}, 20'h0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    step(40);
    chk("idle_d", d_o, 4'h0);

    // Clean press and release on channel 0.
    e0 = cyc;
    d_i[0] = 1'b0;
    push(e0 + 9,  "ch0_pre",  4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    push(e0 + 10, "ch0_rise", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    step(15);
    e1 = cyc;
    d_i[0] = 1'b1;
    push(e1 + 9,  "ch0_hold", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    push(e1 + 10, "ch0_fall", 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    step(20);

    // Glitch on channel 1 restarts the debounce count.
    d_i[1] = 1'b0;
    step(7);
    d_i[1] = 1'b1;
    step(1);
    d_i[1] = 1'b0;
    e0 = cyc;
    push(e0 + 9,  "ch1_pre",  4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    push(e0 + 10, "ch1_rise", 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    step(25);
    e1 = cyc;
    d_i[1] = 1'b1;
    push(e1 + 10, "ch1_fall", 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
    step(20);

    // Channel 3 released so d_o falls while the hold count is LCN-1: no long press.
    e0 = cyc;
    d_i[3] = 1'b0;
    push(e0 + 10, "ch3_rise", 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
    step(31);
    d_i[3] = 1'b1;
    push(e0 + 41, "ch3_fall_at_lcn_m1", 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000);
    step(45);

    // Long press on channel 2.
    e0 = cyc;
    d_i[2] = 1'b0;
    push(e0 + 10, "ch2_rise",     4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
    push(e0 + 41, "ch2_pre_long", 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    push(e0 + 42, "ch2_long",     4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    push(e0 + 58, "ch2_repeat1",  4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    push(e0 + 74, "ch2_repeat2",  4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
`endif
    step(78);
    d_i[2] = 1'b1;
    push(e0 + 87, "ch2_prefall",  4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    push(e0 + 88, "ch2_fall",     4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
    step(15);

    // Simultaneous press on channels 0 and 3, then reset mid-release of channel 3.
    e0 = cyc;
    d_i[0] = 1'b0;
    d_i[3] = 1'b0;
    push(e0 + 10, "ch03_rise", 4'b1001, 4'b1001, 4'b0000, 4'b0000, 4'b0000);
    step(15);
    d_i[3] = 1'b1;
    step(5);
    reset_n = 1'b0;
    d_i     = 4'hF;
    step(3);
    chk("reset_mid_press", {held_o, long_o, fall_o, rise_o, d_o}, 20'h0);
    reset_n = 1'b1;
    step(30);
    chk("post_reset_d", d_o, 4'h0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
